// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA fill arbiter.
package vga_pkg;

    localparam int FB_WIDTH  = 160;
    localparam int FB_HEIGHT = 120;
    localparam int ADDR_W    = 15;
    localparam int COLOR_W   = 3;

    localparam logic [2:0] REG_X0     = 3'd0;
    localparam logic [2:0] REG_Y0     = 3'd1;
    localparam logic [2:0] REG_W      = 3'd2;
    localparam logic [2:0] REG_H      = 3'd3;
    localparam logic [2:0] REG_COLOR  = 3'd4;
    localparam logic [2:0] REG_CTRL   = 3'd5;
    localparam logic [2:0] REG_PIXCNT = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fill_state_t;

endpackage

// File: rtl/vga_fill_walker.sv
// Rectangle walker: tracks x, y and the row base address so that the pixel
// loop only ever adds; the single multiply happens at load time in the top.
module vga_fill_walker
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [7:0]        x0,
    input  logic [8:0]        x_end,
    input  logic [6:0]        y0,
    input  logic [7:0]        y_end,
    input  logic [ADDR_W-1:0] row_base0,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [7:0]        x_q;
    logic [7:0]        x0_q;
    logic [8:0]        x_end_q;
    logic [6:0]        y_q;
    logic [7:0]        y_end_q;
    logic [ADDR_W-1:0] row_base_q;
    logic              row_end;

    // Current pixel address and end-of-row / end-of-rectangle flags.
    always_comb begin
        row_end = (({1'b0, x_q} + 9'd1) == x_end_q);
        last    = row_end && (({1'b0, y_q} + 8'd1) == y_end_q);
        addr    = row_base_q + ADDR_W'(x_q);
    end

    // Shadow the clipped rectangle on load, then advance one pixel per step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q        <= '0;
            x0_q       <= '0;
            x_end_q    <= '0;
            y_q        <= '0;
            y_end_q    <= '0;
            row_base_q <= '0;
        end else if (load) begin
            x_q        <= x0;
            x0_q       <= x0;
            x_end_q    <= x_end;
            y_q        <= y0;
            y_end_q    <= y_end;
            row_base_q <= row_base0;
        end else if (step) begin
            if (row_end) begin
                x_q        <= x0_q;
                y_q        <= y_q + 7'd1;
                row_base_q <= row_base_q + ADDR_W'(FB_WIDTH);
            end else begin
                x_q <= x_q + 8'd1;
            end
        end
    end

endmodule

// File: rtl/vga_fill_arbiter.sv
// Framebuffer write-port arbiter: CPU stores always win, the rectangle-fill
// engine uses every cycle the CPU leaves free.
//
//   state | meaning
//   IDLE  | waiting for a start; fb_* passes cpu_* through
//   RUN   | filling; one engine pixel per cycle without a CPU store
//   DONE  | one-cycle completion pulse, then back to IDLE
module vga_fill_arbiter
    import vga_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_we,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [COLOR_W-1:0] cpu_color,
    input  logic               cfg_we,
    input  logic [2:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    output logic [31:0]        cfg_rdata,
    output logic               busy,
    output logic               done_pulse,
    output logic               fb_we,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_color
);

    localparam logic [8:0] X_LIM = 9'(FB_WIDTH);
    localparam logic [7:0] Y_LIM = 8'(FB_HEIGHT);

    fill_state_t        state, state_nx;
    logic [7:0]         x0_r, w_r;
    logic [6:0]         y0_r, h_r;
    logic [COLOR_W-1:0] color_r, color_sh;
    logic [15:0]        pixcnt_r;
    logic               done_sticky, degen_q;
    logic [8:0]         x_sum, x_end;
    logic [7:0]         y_sum, y_end;
    logic               start_req, degenerate, load, step, last;
    logic [ADDR_W-1:0]  row_base0, walk_addr;
    logic [31:0]        rd_mux;
    logic               unused_wdata;

    assign unused_wdata = ^cfg_wdata[31:8];

    // Start decode, clipping and the one-time row base multiply.
    always_comb begin
        start_req  = cfg_we && (cfg_addr == REG_CTRL) && cfg_wdata[0] && (state == IDLE);
        x_sum      = {1'b0, x0_r} + {1'b0, w_r};
        y_sum      = {1'b0, y0_r} + {1'b0, h_r};
        x_end      = (x_sum > X_LIM) ? X_LIM : x_sum;
        y_end      = (y_sum > Y_LIM) ? Y_LIM : y_sum;
        degenerate = (w_r == 8'd0) || (h_r == 7'd0) ||
                     ({1'b0, x0_r} >= X_LIM) || ({1'b0, y0_r} >= Y_LIM);
        load       = start_req && !degenerate;
        step       = (state == RUN) && !cpu_we;
        row_base0  = ADDR_W'(y0_r) * ADDR_W'(FB_WIDTH);
    end

    vga_fill_walker u_walker (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .x0        (x0_r),
        .x_end     (x_end),
        .y0        (y0_r),
        .y_end     (y_end),
        .row_base0 (row_base0),
        .addr      (walk_addr),
        .last      (last)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state plus the write-port mux; the CPU is passed through unless the
    // engine owns a free cycle.
    always_comb begin
        state_nx   = state;
        fb_we      = cpu_we;
        fb_addr    = cpu_addr;
        fb_color   = cpu_color;
        busy       = (state != IDLE);
        done_pulse = (state == DONE) || degen_q;
        case (state)
            IDLE: if (load) state_nx = RUN;
            RUN: begin
                if (step) begin
                    fb_we    = 1'b1;
                    fb_addr  = walk_addr;
                    fb_color = color_sh;
                    if (last) state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Config registers, colour shadow, pixel counter and completion flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x0_r        <= '0;
            y0_r        <= '0;
            w_r         <= '0;
            h_r         <= '0;
            color_r     <= '0;
            color_sh    <= '0;
            pixcnt_r    <= '0;
            done_sticky <= 1'b0;
            degen_q     <= 1'b0;
        end else begin
            if (cfg_we) begin
                case (cfg_addr)
                    REG_X0:    x0_r    <= cfg_wdata[7:0];
                    REG_Y0:    y0_r    <= cfg_wdata[6:0];
                    REG_W:     w_r     <= cfg_wdata[7:0];
                    REG_H:     h_r     <= cfg_wdata[6:0];
                    REG_COLOR: color_r <= cfg_wdata[2:0];
                    default:   ;
                endcase
            end
            degen_q <= start_req && degenerate;
            if (start_req) begin
                pixcnt_r    <= '0;
                done_sticky <= degenerate;
                if (!degenerate) color_sh <= color_r;
            end else if (step) begin
                pixcnt_r <= pixcnt_r + 16'd1;
            end
            if ((state == RUN) && (state_nx == DONE)) done_sticky <= 1'b1;
        end
    end

    // Register read mux; unused bits and index 7 read as zero.
    always_comb begin
        rd_mux = '0;
        case (cfg_addr)
            REG_X0:     rd_mux = {24'd0, x0_r};
            REG_Y0:     rd_mux = {25'd0, y0_r};
            REG_W:      rd_mux = {24'd0, w_r};
            REG_H:      rd_mux = {25'd0, h_r};
            REG_COLOR:  rd_mux = {29'd0, color_r};
            REG_CTRL:   rd_mux = {30'd0, done_sticky, busy};
            REG_PIXCNT: rd_mux = {16'd0, pixcnt_r};
            default:    rd_mux = '0;
        endcase
    end

    // Registered read data: one cycle behind cfg_addr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cfg_rdata <= '0;
        else     cfg_rdata <= rd_mux;
    end

endmodule

// File: tb/tb_vga_fill_arbiter.sv
module tb_vga_fill_arbiter;
    import vga_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               cpu_we;
    logic [ADDR_W-1:0]  cpu_addr;
    logic [COLOR_W-1:0] cpu_color;
    logic               cfg_we;
    logic [2:0]         cfg_addr;
    logic [31:0]        cfg_wdata;
    logic [31:0]        cfg_rdata;
    logic               busy, done_pulse, fb_we;
    logic [ADDR_W-1:0]  fb_addr;
    logic [COLOR_W-1:0] fb_color;

    vga_fill_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_color  (cpu_color),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .busy       (busy),
        .done_pulse (done_pulse),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_color   (fb_color)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int wr_addr[$];
    int wr_col[$];
    int wr_cyc[$];
    int done_cnt = 0;
    int done_cyc = -1;

    // Record every framebuffer write and done pulse mid-cycle.
    always @(negedge clk) begin
        if (fb_we) begin
            wr_addr.push_back(int'(fb_addr));
            wr_col.push_back(int'(fb_color));
            wr_cyc.push_back(cyc);
        end
        if (done_pulse) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        wr_addr.delete();
        wr_col.delete();
        wr_cyc.delete();
        done_cnt = 0;
        done_cyc = -1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        @(posedge clk);
        #1;
        cfg_we    = 1'b0;
        cfg_wdata = '0;
    endtask

    task automatic cfg_read(input logic [2:0] a, output logic [31:0] d);
        cfg_addr = a;
        @(posedge clk);
        #1;
        d = cfg_rdata;
    endtask

    task automatic program_fill(input int x0, input int y0, input int w, input int h, input int c);
        cfg_write(REG_X0, 32'(x0));
        cfg_write(REG_Y0, 32'(y0));
        cfg_write(REG_W, 32'(w));
        cfg_write(REG_H, 32'(h));
        cfg_write(REG_COLOR, 32'(c));
    endtask

    task automatic start_fill(output int s);
        s = cyc;
        cfg_write(REG_CTRL, 32'd1);
    endtask

    task automatic check_writes(input string tag, input int ea[$], input int ec[$]);
        int ga, gc;
        check({tag, "_count"}, 32'(wr_addr.size()), 32'(ea.size()));
        foreach (ea[i]) begin
            ga = (i < wr_addr.size()) ? wr_addr[i] : -1;
            gc = (i < wr_col.size()) ? wr_col[i] : -1;
            check($sformatf("%s_addr%0d", tag, i), 32'(ga), 32'(ea[i]));
            check($sformatf("%s_col%0d", tag, i), 32'(gc), 32'(ec[i]));
        end
    endtask

    logic [31:0] rd;
    int s;

    initial begin
        rst       = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_color = '0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        idle(2);
        check("rst_fb_we", 32'(fb_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done_pulse), 32'd0);
        check("rst_rdata", cfg_rdata, 32'd0);
        rst = 1'b0;
        idle(1);

        // Uncontended fill
        program_fill(10, 5, 3, 2, 5);
        clear_mon();
        start_fill(s);
        idle(12);
        check_writes("fill", '{810, 811, 812, 970, 971, 972}, '{5, 5, 5, 5, 5, 5});
        check("fill_first_cyc", 32'(wr_cyc.size() > 0 ? wr_cyc[0] - s : -1), 32'd1);
        check("fill_last_cyc", 32'(wr_cyc.size() > 5 ? wr_cyc[5] - s : -1), 32'd6);
        check("fill_done_cnt", 32'(done_cnt), 32'd1);
        check("fill_done_cyc", 32'(done_cyc - s), 32'd7);
        cfg_read(REG_PIXCNT, rd);
        check("fill_pixcnt", rd, 32'd6);
        cfg_read(REG_CTRL, rd);
        check("fill_ctrl", rd, 32'd2);

        // Contention: CPU stores on fill cycles 2 and 3
        clear_mon();
        start_fill(s);
        idle(1);
        cpu_we    = 1'b1;
        cpu_addr  = 15'd100;
        cpu_color = 3'd2;
        idle(2);
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_color = '0;
        idle(10);
        check_writes("cont", '{810, 100, 100, 811, 812, 970, 971, 972}, '{5, 2, 2, 5, 5, 5, 5, 5});
        check("cont_done_cyc", 32'(done_cyc - s), 32'd9);
        cfg_read(REG_PIXCNT, rd);
        check("cont_pixcnt", rd, 32'd6);

        // Clipping at the bottom-right corner
        program_fill(158, 119, 5, 5, 6);
        clear_mon();
        start_fill(s);
        idle(8);
        check_writes("clip", '{19198, 19199}, '{6, 6});
        check("clip_done_cnt", 32'(done_cnt), 32'd1);
        cfg_read(REG_PIXCNT, rd);
        check("clip_pixcnt", rd, 32'd2);

        // Degenerate start
        cfg_write(REG_W, 32'd0);
        clear_mon();
        start_fill(s);
        cfg_read(REG_CTRL, rd);
        check("degen_ctrl", rd, 32'd2);
        idle(4);
        check("degen_writes", 32'(wr_addr.size()), 32'd0);
        check("degen_done_cnt", 32'(done_cnt), 32'd1);
        check("degen_done_cyc", 32'(done_cyc - s), 32'd1);
        cfg_read(REG_PIXCNT, rd);
        check("degen_pixcnt", rd, 32'd0);

        // Start ignored while busy
        program_fill(20, 0, 4, 1, 3);
        clear_mon();
        start_fill(s);
        cfg_write(REG_X0, 32'd0);
        cfg_write(REG_CTRL, 32'd1);
        idle(10);
        check_writes("busy", '{20, 21, 22, 23}, '{3, 3, 3, 3});
        check("busy_done_cnt", 32'(done_cnt), 32'd1);
        cfg_read(REG_X0, rd);
        check("busy_x0_reg", rd, 32'd0);

        // Reset mid-fill
        program_fill(20, 0, 4, 1, 3);
        clear_mon();
        start_fill(s);
        idle(2);
        rst = 1'b1;
        #1;
        check("rstmid_fb_we", 32'(fb_we), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        idle(2);
        rst = 1'b0;
        idle(4);
        check("rstmid_writes", 32'(wr_addr.size()), 32'd2);
        check("rstmid_done_cnt", 32'(done_cnt), 32'd0);
        cfg_read(REG_CTRL, rd);
        check("rstmid_ctrl", rd, 32'd0);
        program_fill(1, 0, 1, 1, 7);
        clear_mon();
        start_fill(s);
        idle(6);
        check_writes("after_rst", '{1}, '{7});
        check("after_rst_done_cnt", 32'(done_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
